audio_out_fifo: RTL and testbench

- Stereo sample elastic buffer between the filter/DSP stage and the audio CODEC write port.
- Accepts filtered left/right sample pairs through a valid/ready handshake.
- Feeds the CODEC on every write_ready with a priming threshold and underrun recovery, so the DAC never stalls on filter jitter.
- Reports fill level and underrun statistics for debug LEDs/HEX.

---
 rtl/audio_out_fifo_if.sv | 24 ++
 rtl/audio_out_fifo.sv | 148 ++++++++++++++
 tb/tb_audio_out_fifo.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/audio_out_fifo_if.sv
// Stereo sample handshake bundle: producer push side plus CODEC write side.
// The slave modport is the FIFO's view; master is the surrounding environment.
interface audio_out_fifo_if #(
    parameter int DATA_W = 24
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_left;
    logic [DATA_W-1:0] in_right;
    logic              write_ready;
    logic              write;
    logic [DATA_W-1:0] writedata_left;
    logic [DATA_W-1:0] writedata_right;

    modport slave (
        input  in_valid, in_left, in_right, write_ready,
        output in_ready, write, writedata_left, writedata_right
    );

    modport master (
        output in_valid, in_left, in_right, write_ready,
        input  in_ready, write, writedata_left, writedata_right
    );
endinterface

// File: rtl/audio_out_fifo.sv
// audio_out_fifo: stereo elastic buffer between the DSP stage and the CODEC
// write port. Drains only once PREFILL pairs are queued (PRIME -> RUN) and
// falls back to PRIME on an underrun, feeding a fill value meanwhile.
// Optional macro AUD_OUT_HOLD_LAST_EN: fill value is the last popped pair
// instead of silence, so the DAC holds its level rather than clicking to 0.
module audio_out_fifo #(
    parameter int DATA_W  = 24,
    parameter int DEPTH   = 16,
    parameter int PREFILL = 8
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    audio_out_fifo_if.slave          bus,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     running,
    output logic [15:0]              underrun_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || PREFILL < 1 || PREFILL > DEPTH) begin : g_param_err
            $error("audio_out_fifo: DEPTH must be a power of two >= 2 and PREFILL in 1..DEPTH");
        end
    endgenerate

    typedef enum logic {PRIME = 1'b0, RUN = 1'b1} state_t;

    state_t            state_q, state_d;
    logic              running_q, running_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [15:0]       underrun_count_q, underrun_count_d;

    logic [DATA_W-1:0] mem_l [DEPTH];
    logic [DATA_W-1:0] mem_r [DEPTH];

    logic              full, empty, push, pop, underrun;
    logic [DATA_W-1:0] head_l, head_r, fill_l, fill_r;

    // Handshake qualifiers; full blocks a push even when a pop shares the cycle.
    assign full         = (level_q == LW'(DEPTH));
    assign empty        = (level_q == '0);
    assign bus.in_ready = ~full & ~reset;
    assign bus.write    = bus.write_ready & ~reset;
    assign push         = bus.in_valid & bus.in_ready;
    assign pop          = (state_q == RUN) & bus.write & ~empty;
    assign underrun     = (state_q == RUN) & bus.write & empty;

    assign head_l = mem_l[rd_ptr_q];
    assign head_r = mem_r[rd_ptr_q];

`ifdef AUD_OUT_HOLD_LAST_EN
    logic [DATA_W-1:0] fill_l_q, fill_l_d, fill_r_q, fill_r_d;

    // Remember the pair most recently handed to the CODEC.
    always_comb begin
        fill_l_d = fill_l_q;
        fill_r_d = fill_r_q;
        if (pop) begin
            fill_l_d = head_l;
            fill_r_d = head_r;
        end
    end

    // Hold-last capture registers.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            fill_l_q <= '0;
            fill_r_q <= '0;
        end else begin
            fill_l_q <= fill_l_d;
            fill_r_q <= fill_r_d;
        end
    end

    assign fill_l = fill_l_q;
    assign fill_r = fill_r_q;
`else
    assign fill_l = '0;
    assign fill_r = '0;
`endif

    // Head of queue only while draining with data; otherwise the fill value.
    assign bus.writedata_left  = (state_q == RUN && !empty) ? head_l : fill_l;
    assign bus.writedata_right = (state_q == RUN && !empty) ? head_r : fill_r;

    // Next-state: priming/run control, pointers, occupancy, underrun stats.
    always_comb begin
        state_d          = state_q;
        wr_ptr_d         = wr_ptr_q;
        rd_ptr_d         = rd_ptr_q;
        level_d          = level_q;
        underrun_count_d = underrun_count_q;

        case (state_q)
            PRIME:   if (level_q >= LW'(PREFILL)) state_d = RUN;
            RUN:     if (underrun) state_d = PRIME;
            default: state_d = PRIME;
        endcase

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        if (underrun && underrun_count_q != 16'hFFFF)
            underrun_count_d = underrun_count_q + 16'd1;

        running_d = (state_d == RUN);
    end

    // Control state registers.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q          <= PRIME;
            running_q        <= 1'b0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            level_q          <= '0;
            underrun_count_q <= '0;
        end else begin
            state_q          <= state_d;
            running_q        <= running_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            level_q          <= level_d;
            underrun_count_q <= underrun_count_d;
        end
    end

    // Sample storage; contents survive reset, only the pointers are cleared.
    always_ff @(posedge CLOCK_50) begin
        if (push) begin
            mem_l[wr_ptr_q] <= bus.in_left;
            mem_r[wr_ptr_q] <= bus.in_right;
        end
    end

    assign level          = level_q;
    assign running        = running_q;
    assign underrun_count = underrun_count_q;
endmodule

// File: tb/tb_audio_out_fifo.sv
// Directed bench for audio_out_fifo: table of per-cycle vectors for the
// prime/drain path, then hand sequences for full, underrun, saturation,
// latency and mid-stream reset.
module tb_audio_out_fifo;
    localparam int DW = 24;
`ifdef AUD_OUT_HOLD_LAST_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  level;
    logic        running;
    logic [15:0] underrun_count;
    int          checks = 0;
    int          failures = 0;

    audio_out_fifo_if #(.DATA_W(DW)) bus ();

    audio_out_fifo #(.DATA_W(DW), .DEPTH(16), .PREFILL(8)) dut (
        .CLOCK_50      (clk),
        .reset         (reset),
        .bus           (bus),
        .level         (level),
        .running       (running),
        .underrun_count(underrun_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          v;
        logic [DW-1:0] l, r;
        logic          w;
        logic          e_rdy, e_wr;
        logic [DW-1:0] e_l, e_r;
        logic [4:0]    e_lvl;
        logic          e_run;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [DW-1:0] n(input int i);
        return DW'(-i);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Apply inputs on the falling edge; outputs are sampled 1 ns later.
    task automatic drive(input logic v, input logic [DW-1:0] l, input logic [DW-1:0] r, input logic w);
        @(negedge clk);
        bus.in_valid    = v;
        bus.in_left     = l;
        bus.in_right    = r;
        bus.write_ready = w;
        #1;
    endtask

    task automatic add(input logic v, input logic [DW-1:0] l, input logic [DW-1:0] r, input logic w,
                       input logic rdy, input logic wr, input logic [DW-1:0] el, input logic [DW-1:0] er,
                       input logic [4:0] lvl, input logic run);
        tbl.push_back('{v, l, r, w, rdy, wr, el, er, lvl, run});
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.write_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Prime with 8 pairs, enter RUN, drain them, then underrun once.
    task automatic underrun_cycle();
        for (int i = 1; i <= 8; i++) drive(1'b1, DW'(i), n(i), 1'b0);
        drive(1'b0, '0, '0, 1'b0);
        drive(1'b0, '0, '0, 1'b0);
        for (int i = 1; i <= 8; i++) drive(1'b0, '0, '0, 1'b1);
        drive(1'b0, '0, '0, 1'b1);
        drive(1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        // ---- vector table: idle after reset, prime 8, enter RUN, drain 8 ----
        for (int i = 0; i < 3; i++) add(0, '0, '0, 1, 1, 1, '0, '0, 5'd0, 0);
        for (int i = 1; i <= 8; i++) add(1, DW'(i), n(i), 0, 1, 0, '0, '0, 5'(i - 1), 0);
        add(0, '0, '0, 0, 1, 0, '0, '0, 5'd8, 0);
        add(0, '0, '0, 0, 1, 0, DW'(1), n(1), 5'd8, 1);
        add(0, '0, '0, 1, 1, 1, DW'(1), n(1), 5'd8, 1);
        add(0, '0, '0, 0, 1, 0, DW'(2), n(2), 5'd7, 1);
        for (int k = 2; k <= 8; k++) add(0, '0, '0, 1, 1, 1, DW'(k), n(k), 5'(9 - k), 1);

        // ---- reset state ----
        reset = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_left = '0;
        bus.in_right = '0;
        bus.write_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_write", bus.write, 0);
        chk("rst_level", level, 0);
        chk("rst_running", running, 0);
        chk("rst_underruns", underrun_count, 0);
        @(negedge clk);
        reset = 1'b0;
        bus.in_valid = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].l, tbl[i].r, tbl[i].w);
            chk($sformatf("row%0d_in_ready", i), bus.in_ready, tbl[i].e_rdy);
            chk($sformatf("row%0d_write", i), bus.write, tbl[i].e_wr);
            chk($sformatf("row%0d_wd_left", i), bus.writedata_left, tbl[i].e_l);
            chk($sformatf("row%0d_wd_right", i), bus.writedata_right, tbl[i].e_r);
            chk($sformatf("row%0d_level", i), level, tbl[i].e_lvl);
            chk($sformatf("row%0d_running", i), running, tbl[i].e_run);
        end

        // ---- underrun from RUN with empty FIFO, then re-prime ----
        drive(1'b0, '0, '0, 1'b1);
        chk("ur_pre_running", running, 1);
        chk("ur_fill_left", bus.writedata_left, HOLD ? DW'(8) : '0);
        chk("ur_fill_right", bus.writedata_right, HOLD ? n(8) : '0);
        drive(1'b0, '0, '0, 1'b1);
        chk("ur_count", underrun_count, 1);
        chk("ur_running", running, 0);
        chk("ur_post_fill_left", bus.writedata_left, HOLD ? DW'(8) : '0);
        for (int i = 1; i <= 8; i++) drive(1'b1, DW'(100 + i), n(100 + i), 1'b0);
        drive(1'b0, '0, '0, 1'b0);
        chk("reprime_level", level, 8);
        chk("reprime_still_prime", running, 0);
        drive(1'b0, '0, '0, 1'b0);
        chk("reprime_running", running, 1);
        chk("reprime_head", bus.writedata_left, 101);
        chk("reprime_count_kept", underrun_count, 1);

        // ---- full: extra pushes ignored, even alongside a pop ----
        do_reset();
        for (int i = 1; i <= 16; i++) drive(1'b1, DW'(i), n(i), 1'b0);
        drive(1'b1, DW'('h999), DW'('h999), 1'b0);
        chk("full_in_ready", bus.in_ready, 0);
        chk("full_level", level, 16);
        drive(1'b1, DW'('h777), DW'('h777), 1'b1);
        chk("full_pop_in_ready", bus.in_ready, 0);
        chk("full_pop_head", bus.writedata_left, 1);
        drive(1'b0, '0, '0, 1'b0);
        chk("after_pop_in_ready", bus.in_ready, 1);
        chk("after_pop_level", level, 15);
        for (int k = 2; k <= 16; k++) begin
            drive(1'b0, '0, '0, 1'b1);
            chk($sformatf("drain%0d_left", k), bus.writedata_left, DW'(k));
            chk($sformatf("drain%0d_right", k), bus.writedata_right, n(k));
        end

        // ---- latency: push into empty FIFO in RUN, head visible next cycle ----
        drive(1'b1, DW'('h123), DW'('h456), 1'b0);
        chk("lat_empty_level", level, 0);
        chk("lat_fill_left", bus.writedata_left, HOLD ? DW'(16) : '0);
        drive(1'b0, '0, '0, 1'b0);
        chk("lat_head_left", bus.writedata_left, 'h123);
        chk("lat_head_right", bus.writedata_right, 'h456);
        chk("lat_level", level, 1);
        drive(1'b0, '0, '0, 1'b1);
        chk("lat_pop_left", bus.writedata_left, 'h123);

        // ---- saturation: preload the counter near the top, then underrun ----
        drive(1'b0, '0, '0, 1'b0);
        force dut.underrun_count_q = 16'hFFFD;
        #1;
        release dut.underrun_count_q;
        drive(1'b0, '0, '0, 1'b1);
        drive(1'b0, '0, '0, 1'b0);
        chk("sat_fffe", underrun_count, 16'hFFFE);
        chk("sat_running", running, 0);
        underrun_cycle();
        chk("sat_ffff", underrun_count, 16'hFFFF);
        underrun_cycle();
        chk("sat_hold", underrun_count, 16'hFFFF);

        // ---- reset mid-stream in RUN with level 5 ----
        do_reset();
        for (int i = 1; i <= 8; i++) drive(1'b1, DW'(200 + i), n(200 + i), 1'b0);
        drive(1'b0, '0, '0, 1'b0);
        drive(1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, '0, '0, 1'b1);
        drive(1'b0, '0, '0, 1'b1);
        chk("mid_level", level, 5);
        chk("mid_running", running, 1);
        chk("mid_write", bus.write, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_write", bus.write, 0);
        chk("mid_rst_in_ready", bus.in_ready, 0);
        chk("mid_rst_level", level, 0);
        chk("mid_rst_running", running, 0);
        @(negedge clk);
        reset = 1'b0;
        bus.write_ready = 1'b0;
        for (int i = 1; i <= 8; i++) drive(1'b1, DW'(300 + i), n(300 + i), 1'b0);
        drive(1'b0, '0, '0, 1'b0);
        drive(1'b0, '0, '0, 1'b1);
        chk("post_rst_running", running, 1);
        chk("post_rst_head_left", bus.writedata_left, 301);
        chk("post_rst_head_right", bus.writedata_right, n(301));
        drive(1'b0, '0, '0, 1'b1);
        chk("post_rst_second", bus.writedata_left, 302);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
